// File: rtl/territory_tally_pkg.sv
// territory_tally_pkg: screen geometry, player colour codes, FSM states and {x,y} address packing
package territory_tally_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int CNT_W    = 15;
    localparam logic [2:0] PLAYER_COL [4] = '{3'b001, 3'b010, 3'b100, 3'b110};
    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, DECIDE, DONE} state_t;
    function automatic logic [14:0] pack_xy(input logic [7:0] x, input logic [6:0] y);
        return {x, y};
    endfunction
endpackage

// File: rtl/territory_tally_if.sv
// territory_tally_if: request/RAM-read/result bundle of the territory tally
//   slave  (tally side): start, ram_q in; ram_address, busy, done, p1..p4_count, winner out
//   master (requester/RAM side): the mirror image
interface territory_tally_if;
    import territory_tally_pkg::*;
    logic             start;
    logic [2:0]       ram_q;
    logic [14:0]      ram_address;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] p1_count;
    logic [CNT_W-1:0] p2_count;
    logic [CNT_W-1:0] p3_count;
    logic [CNT_W-1:0] p4_count;
    logic [1:0]       winner;
    modport master (
        output start, ram_q,
        input  ram_address, busy, done, p1_count, p2_count, p3_count, p4_count, winner
    );
    modport slave (
        input  start, ram_q,
        output ram_address, busy, done, p1_count, p2_count, p3_count, p4_count, winner
    );
endinterface

// File: rtl/territory_tally_xy_scanner.sv
// territory_tally_xy_scanner: x/y sweep counters (y inner) producing the registered RAM read address
//   CLOCK_50     in   system clock
//   resetn       in   asynchronous active-low reset
//   clear        in   restart at {0,0}
//   step         in   advance one cell; holds once the last cell is reached
//   last         out  current address is (H_RES-1, V_RES-1)
//   ram_address  out  {x,y}
module territory_tally_xy_scanner
    import territory_tally_pkg::*;
#(
    parameter int H_RES = SCREEN_W,
    parameter int V_RES = SCREEN_H
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        clear,
    input  logic        step,
    output logic        last,
    output logic [14:0] ram_address
);
    logic [7:0] x;
    logic [6:0] y;
    logic       y_wrap;

    assign y_wrap      = y == 7'(V_RES - 1);
    assign last        = y_wrap && (x == 8'(H_RES - 1));
    assign ram_address = pack_xy(x, y);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (step && !last) begin
            y <= y_wrap ? '0 : y + 7'd1;
            x <= y_wrap ? x + 8'd1 : x;
        end
    end
endmodule

// File: rtl/territory_tally.sv
// territory_tally: sweeps the territory RAM once per start and reports per-player counts and the winner
//   CLOCK_50  in     system clock
//   resetn    in     asynchronous active-low reset
//   bus       slave  start, ram_q in; ram_address, busy, done, p1..p4_count, winner out
module territory_tally
    import territory_tally_pkg::*;
#(
    parameter int H_RES       = SCREEN_W,
    parameter int V_RES       = SCREEN_H,
    parameter int RAM_LATENCY = 1
) (
    input logic              CLOCK_50,
    input logic              resetn,
    territory_tally_if.slave bus
);
    // vld holds only the final in-flight read when the drain is complete
    localparam logic [RAM_LATENCY-1:0] VLD_LAST = RAM_LATENCY'(1) << (RAM_LATENCY - 1);

    state_t                 state, state_nx;
    logic [RAM_LATENCY-1:0] vld;
    logic [CNT_W-1:0]       cnt [4];
    logic [1:0]             win, win_nx;
    logic                   last, accept;

    assign accept          = (state == IDLE) && bus.start;
    assign bus.busy        = state != IDLE;
    assign bus.done        = state == DONE;
    assign bus.p1_count    = cnt[0];
    assign bus.p2_count    = cnt[1];
    assign bus.p3_count    = cnt[2];
    assign bus.p4_count    = cnt[3];
    assign bus.winner      = win;

    territory_tally_xy_scanner #(.H_RES(H_RES), .V_RES(V_RES)) u_scan (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .clear       (accept),
        .step        (state == SCAN),
        .last        (last),
        .ram_address (bus.ram_address)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? SCAN : IDLE;
            SCAN:    state_nx = last ? DRAIN : SCAN;
            DRAIN:   state_nx = ((vld & ~VLD_LAST) == '0) ? DECIDE : DRAIN;
            DECIDE:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // strict greater-than keeps the lowest index on ties
    always_comb begin
        win_nx = 2'd0;
        for (int i = 1; i < 4; i++)
            if (cnt[i] > cnt[win_nx]) win_nx = 2'(i);
    end

    // every SCAN cycle puts one read on the bus; its data arrives RAM_LATENCY cycles later
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            vld <= '0;
            win <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            vld <= (vld << 1) | RAM_LATENCY'(state == SCAN);
            for (int i = 0; i < 4; i++)
                if (accept) cnt[i] <= '0;
                else if (vld[RAM_LATENCY-1] && bus.ram_q == PLAYER_COL[i]) cnt[i] <= cnt[i] + CNT_W'(1);
            if (state == DECIDE) win <= win_nx;
        end
    end
endmodule

// File: tb/tb_territory_tally.sv
// tb_territory_tally: directed sweeps against RAM models at latency 1 and 2 with a cycle-level reference model
module tb_territory_tally;
    import territory_tally_pkg::*;
    localparam int N = SCREEN_W * SCREEN_H;
    localparam int LAT [2] = '{1, 2};

    logic        CLOCK_50 = 1'b0;
    logic        resetn   = 1'b0;
    logic        start [2] = '{1'b0, 1'b0};
    logic [2:0]  mem [2][32768];
    logic [2:0]  q0;
    logic [2:0]  q1 [2];
    logic [14:0] addr [2];
    logic        busy [2];
    logic        done [2];
    logic [14:0] cnt [2][4];
    logic [1:0]  win [2];

    int checks = 0;
    int failures = 0;
    int mcyc [2];
    int exp_cnt [2][4];
    int exp_win [2];
    int new_win [2];
    int order_err [2];
    int seen [2][32768];

    always #5 CLOCK_50 = ~CLOCK_50;

    territory_tally_if bus0 ();
    territory_tally_if bus1 ();

    territory_tally #(.RAM_LATENCY(1)) dut0 (.CLOCK_50(CLOCK_50), .resetn(resetn), .bus(bus0));
    territory_tally #(.RAM_LATENCY(2)) dut1 (.CLOCK_50(CLOCK_50), .resetn(resetn), .bus(bus1));

    always @(posedge CLOCK_50) begin
        q0    <= mem[0][bus0.ram_address];
        q1[0] <= mem[1][bus1.ram_address];
        q1[1] <= q1[0];
    end

    assign bus0.start = start[0];
    assign bus1.start = start[1];
    assign bus0.ram_q = q0;
    assign bus1.ram_q = q1[1];
    assign addr[0] = bus0.ram_address;
    assign addr[1] = bus1.ram_address;
    assign busy[0] = bus0.busy;
    assign busy[1] = bus1.busy;
    assign done[0] = bus0.done;
    assign done[1] = bus1.done;
    assign win[0]  = bus0.winner;
    assign win[1]  = bus1.winner;
    assign cnt[0][0] = bus0.p1_count;
    assign cnt[0][1] = bus0.p2_count;
    assign cnt[0][2] = bus0.p3_count;
    assign cnt[0][3] = bus0.p4_count;
    assign cnt[1][0] = bus1.p1_count;
    assign cnt[1][1] = bus1.p2_count;
    assign cnt[1][2] = bus1.p3_count;
    assign cnt[1][3] = bus1.p4_count;

    task automatic chk(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    // Reference tally: count every on-screen cell by colour, winner = first player holding the maximum
    function automatic void model_sweep(input int d);
        for (int i = 0; i < 4; i++) exp_cnt[d][i] = 0;
        for (int x = 0; x < SCREEN_W; x++)
            for (int y = 0; y < SCREEN_H; y++)
                case (mem[d][x * 128 + y])
                    3'b001: exp_cnt[d][0]++;
                    3'b010: exp_cnt[d][1]++;
                    3'b100: exp_cnt[d][2]++;
                    3'b110: exp_cnt[d][3]++;
                    default: ;
                endcase
        new_win[d] = 0;
        for (int i = 1; i < 4; i++)
            if (exp_cnt[d][i] > exp_cnt[d][new_win[d]]) new_win[d] = i;
    endfunction

    // mcyc = number of the cycle since the accepting edge (1 = cycle right after it), 0 when idle
    always @(posedge CLOCK_50 or negedge resetn)
        for (int d = 0; d < 2; d++) begin
            if (!resetn) begin
                mcyc[d] = 0;
                exp_win[d] = 0;
                for (int i = 0; i < 4; i++) exp_cnt[d][i] = 0;
            end else if (mcyc[d] != 0) begin
                mcyc[d] = (mcyc[d] == N + LAT[d] + 2) ? 0 : mcyc[d] + 1;
                if (mcyc[d] == N + LAT[d] + 2) exp_win[d] = new_win[d];
            end else if (start[d]) begin
                mcyc[d] = 1;
                model_sweep(d);
                order_err[d] = 0;
                for (int a = 0; a < 32768; a++) seen[d][a] = 0;
            end
        end

    always @(negedge CLOCK_50)
        for (int d = 0; d < 2; d++) begin
            chk("busy", d, int'(busy[d]), int'(mcyc[d] != 0));
            chk("done", d, int'(done[d]), int'(mcyc[d] == N + LAT[d] + 2));
            chk("winner", d, int'(win[d]), exp_win[d]);
            if (mcyc[d] == 0 || mcyc[d] > N + LAT[d])
                for (int i = 0; i < 4; i++)
                    chk($sformatf("p%0d_count", i + 1), d, int'(cnt[d][i]), exp_cnt[d][i]);
            if (mcyc[d] >= 1 && mcyc[d] <= N) begin
                if (int'(addr[d]) != ((mcyc[d] - 1) / SCREEN_H) * 128 + (mcyc[d] - 1) % SCREEN_H)
                    order_err[d]++;
                seen[d][addr[d]]++;
            end
            if (mcyc[d] == N + LAT[d] + 2) begin
                int bad;
                bad = 0;
                for (int a = 0; a < 32768; a++)
                    if (seen[d][a] != ((a / 128 < SCREEN_W && a % 128 < SCREEN_H) ? 1 : 0)) bad++;
                chk("addr_order", d, order_err[d], 0);
                chk("addr_cover", d, bad, 0);
            end
        end

    // off-screen cells hold 001 so any stray read would inflate p1
    task automatic fill(input int d, input int pat);
        for (int a = 0; a < 32768; a++) begin
            int x, y;
            logic [2:0] v;
            x = a / 128;
            y = a % 128;
            if (x >= SCREEN_W || y >= SCREEN_H) v = 3'b001;
            else if (pat == 0) v = 3'b000;
            else if (pat == 1) v = x < 40 ? 3'b001 : x < 80 ? 3'b010 : x < 120 ? 3'b100 : 3'b110;
            else if (pat == 2) v = y == 119 ? 3'b111 : (x == 37 && y == 52) ? 3'b001 : 3'b110;
            else v = (x * SCREEN_H + y < 10000) ? 3'b010 : 3'b100;
            mem[d][a] = v;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // pulse start, then watch a fixed window; lat = cycle number in which done is first seen
    task automatic sweep(input bit s0, input bit s1, input bit hold,
                         output int lat0, output int lat1, output int ndone0);
        int n;
        lat0 = 0;
        lat1 = 0;
        ndone0 = 0;
        start[0] = s0;
        start[1] = s1;
        tick(1);
        start[0] = 1'b0;
        start[1] = 1'b0;
        for (n = 1; n < 19400; n++) begin
            if (done[0]) begin
                ndone0++;
                if (lat0 == 0) lat0 = n;
            end
            if (done[1] && lat1 == 0) lat1 = n;
            start[0] = hold && n >= 1000 && n < 1050;
            tick(1);
        end
        start[0] = 1'b0;
    endtask

    initial begin
        int l0, l1, nd;
        fill(0, 0);
        fill(1, 3);
        tick(3);
        chk("rst_addr", 0, int'(addr[0]), 0);
        chk("rst_addr", 1, int'(addr[1]), 0);
        resetn = 1'b1;
        tick(2);

        sweep(1'b1, 1'b1, 1'b0, l0, l1, nd);
        chk("zero_lat", 0, l0, 19203);
        chk("zero_ndone", 0, nd, 1);
        chk("zero_p1", 0, int'(cnt[0][0]), 0);
        chk("zero_p4", 0, int'(cnt[0][3]), 0);
        chk("zero_win", 0, int'(win[0]), 0);
        chk("lat2_lat", 1, l1, 19204);
        chk("lat2_p1", 1, int'(cnt[1][0]), 0);
        chk("lat2_p2", 1, int'(cnt[1][1]), 10000);
        chk("lat2_p3", 1, int'(cnt[1][2]), 9200);
        chk("lat2_p4", 1, int'(cnt[1][3]), 0);
        chk("lat2_win", 1, int'(win[1]), 1);

        fill(0, 1);
        sweep(1'b1, 1'b0, 1'b0, l0, l1, nd);
        chk("quad_lat", 0, l0, 19203);
        for (int i = 0; i < 4; i++) chk("quad_cnt", 0, int'(cnt[0][i]), 4800);
        chk("quad_win", 0, int'(win[0]), 0);

        fill(0, 2);
        sweep(1'b1, 1'b0, 1'b1, l0, l1, nd);
        chk("hold_lat", 0, l0, 19203);
        chk("hold_ndone", 0, nd, 1);
        chk("p4_p1", 0, int'(cnt[0][0]), 1);
        chk("p4_p2", 0, int'(cnt[0][1]), 0);
        chk("p4_p3", 0, int'(cnt[0][2]), 0);
        chk("p4_p4", 0, int'(cnt[0][3]), 19039);
        chk("p4_win", 0, int'(win[0]), 3);

        fill(0, 3);
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        tick(4999);
        resetn = 1'b0;
        #1;
        chk("rstmid_busy", 0, int'(busy[0]), 0);
        chk("rstmid_done", 0, int'(done[0]), 0);
        chk("rstmid_addr", 0, int'(addr[0]), 0);
        chk("rstmid_p4", 0, int'(cnt[0][3]), 0);
        chk("rstmid_win", 0, int'(win[0]), 0);
        chk("rstmid_win", 1, int'(win[1]), 0);
        chk("rstmid_p2", 1, int'(cnt[1][1]), 0);
        tick(2);
        resetn = 1'b1;
        tick(2);
        sweep(1'b1, 1'b0, 1'b0, l0, l1, nd);
        chk("restart_lat", 0, l0, 19203);
        chk("restart_p2", 0, int'(cnt[0][1]), 10000);
        chk("restart_p3", 0, int'(cnt[0][2]), 9200);
        chk("restart_win", 0, int'(win[0]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
